// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time, byte/half/word lane steering and load formatting.
// Optional REQ-state watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        fault_o
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

    state_t     state;
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic       we_q;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt;
`endif

    function automatic logic illegal(input logic [2:0] f);
        return (f == 3'b011) || (f[2:1] == 2'b11);
    endfunction

    function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
        case (f[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f, input logic [1:0] a);
        case (f[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f, input logic [31:0] d);
        case (f[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Extract the addressed lane and extend according to the signed/unsigned variant.
    function automatic logic [31:0] fmt_load(input logic [2:0] f, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*a +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return rd;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            funct3_q    <= 3'b0;
            off_q       <= 2'b0;
            we_q        <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'b0;
            mem_be_o    <= 4'b0;
            mem_wdata_o <= 32'b0;
            load_data_o <= 32'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            fault_o     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            done_o  <= 1'b0;
            fault_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    funct3_q <= funct3_i;
                    off_q    <= addr_i[1:0];
                    we_q     <= we_i;
                    busy_o   <= 1'b1;
                    if (illegal(funct3_i) || misaligned(funct3_i, addr_i[1:0])) begin
                        state   <= FAULT;
                        fault_o <= 1'b1;
                    end else begin
                        state       <= REQ;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= we_i;
                        mem_addr_o  <= {addr_i[31:2], 2'b00};
                        mem_be_o    <= byte_en(funct3_i, addr_i[1:0]);
                        mem_wdata_o <= lane_data(funct3_i, wdata_i);
`ifdef LSU_TIMEOUT_EN
                        tcnt        <= '0;
`endif
                    end
                end
                REQ: if (mem_ack_i) begin
                    state     <= DONE;
                    done_o    <= 1'b1;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                    if (!we_q)
                        load_data_o <= fmt_load(funct3_q, off_q, mem_rdata_i);
                end
`ifdef LSU_TIMEOUT_EN
                // Abort once the request has waited TIMEOUT_CYCLES cycles without ack.
                else if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state     <= FAULT;
                    fault_o   <= 1'b1;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
`endif
                DONE, FAULT: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: table of single accesses plus hand sequences
// for reset, back-to-back starts, stray acks and the optional timeout.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'b0;
    logic [31:0] addr_i = 32'b0;
    logic [31:0] wdata_i = 32'b0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, load_data_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'b0;
    logic        done_o, busy_o, fault_o;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .load_data_o(load_data_o),
        .done_o(done_o), .busy_o(busy_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] load;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        start_i = 1'b1; we_i = v.we; funct3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
        @(negedge clk);
        start_i = 1'b0;
        if (v.fault) begin
            check($sformatf("v%0d fault pulse", i), {31'b0, fault_o}, 32'd1);
            check($sformatf("v%0d fault no req", i), {31'b0, mem_req_o}, 32'd0);
            check($sformatf("v%0d fault no done", i), {31'b0, done_o}, 32'd0);
            @(negedge clk);
            check($sformatf("v%0d fault one cycle", i), {31'b0, fault_o}, 32'd0);
            check($sformatf("v%0d fault idle busy", i), {31'b0, busy_o}, 32'd0);
            check($sformatf("v%0d fault still no req", i), {31'b0, mem_req_o}, 32'd0);
            check($sformatf("v%0d fault load kept", i), load_data_o, v.load);
        end else begin
            check($sformatf("v%0d req", i), {31'b0, mem_req_o}, 32'd1);
            check($sformatf("v%0d we", i), {31'b0, mem_we_o}, {31'b0, v.we});
            check($sformatf("v%0d addr", i), mem_addr_o, {v.addr[31:2], 2'b00});
            check($sformatf("v%0d be", i), {28'b0, mem_be_o}, {28'b0, v.be});
            if (v.we) check($sformatf("v%0d wdata", i), mem_wdata_o, v.mwdata);
            for (int w = 0; w < v.waits; w++) begin
                start_i = 1'b1; addr_i = 32'hFFFF_FFF0;
                @(negedge clk);
                start_i = 1'b0;
                check($sformatf("v%0d wait%0d req held", i, w), {31'b0, mem_req_o}, 32'd1);
                check($sformatf("v%0d wait%0d be held", i, w), {28'b0, mem_be_o}, {28'b0, v.be});
                check($sformatf("v%0d wait%0d no done", i, w), {31'b0, done_o}, 32'd0);
            end
            mem_ack_i = 1'b1; mem_rdata_i = v.rdata;
            @(negedge clk);
            mem_ack_i = 1'b0; mem_rdata_i = 32'h5555_5555;
            check($sformatf("v%0d done", i), {31'b0, done_o}, 32'd1);
            check($sformatf("v%0d req dropped", i), {31'b0, mem_req_o}, 32'd0);
            check($sformatf("v%0d load", i), load_data_o, v.load);
            @(negedge clk);
            check($sformatf("v%0d done one cycle", i), {31'b0, done_o}, 32'd0);
            check($sformatf("v%0d idle", i), {31'b0, busy_o}, 32'd0);
            check($sformatf("v%0d load held", i), load_data_o, v.load);
        end
    endtask

    initial begin
        //        we    f3      addr          wdata         rdata         w  flt  be       mwdata        load
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        3, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080};
        vecs[4]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0000_0080};
        vecs[5]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0000_0080};
        vecs[6]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001};
        vecs[7]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h8001_7FFF, 0, 1'b0, 4'b0011, 32'h0,        32'h0000_7FFF};
        vecs[8]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h1234_5678, 0, 1'b0, 4'b0010, 32'h0,        32'h0000_0056};
        vecs[9]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0056};
        vecs[10] = '{1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0000_0056};
        vecs[11] = '{1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        2, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0000_0056};
        vecs[12] = '{1'b0, 3'b101, 32'h0000_0001, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0000_0056};

        // Reset state
        #12;
        check("rst req", {31'b0, mem_req_o}, 32'd0);
        check("rst busy", {31'b0, busy_o}, 32'd0);
        check("rst be", {28'b0, mem_be_o}, 32'd0);
        check("rst addr", mem_addr_o, 32'd0);
        check("rst load", load_data_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(i);

        // Stray ack while idle must not complete anything
        @(negedge clk);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD_0BAD;
        @(negedge clk);
        @(negedge clk);
        check("idle ack no done", {31'b0, done_o}, 32'd0);
        check("idle ack load kept", load_data_o, 32'h0000_0056);
        mem_ack_i = 1'b0;

        // Back-to-back: start held through DONE is taken in the following IDLE cycle
        @(negedge clk);
        start_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h104;
        @(negedge clk);
        start_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("b2b first done", {31'b0, done_o}, 32'd1);
        start_i = 1'b1; addr_i = 32'h108;
        @(negedge clk);
        check("b2b idle gap", {31'b0, busy_o}, 32'd0);
        check("b2b no req in idle", {31'b0, mem_req_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        check("b2b second req", {31'b0, mem_req_o}, 32'd1);
        check("b2b second addr", mem_addr_o, 32'h108);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h2222_2222;
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("b2b second load", load_data_o, 32'h2222_2222);

        // Reset in the middle of REQ
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h100;
        @(negedge clk);
        start_i = 1'b0;
        check("mid req active", {31'b0, mem_req_o}, 32'd1);
        #2 reset = 1'b1; mem_ack_i = 1'b1;
        #1;
        check("mid rst req drop", {31'b0, mem_req_o}, 32'd0);
        check("mid rst busy", {31'b0, busy_o}, 32'd0);
        check("mid rst load", load_data_o, 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        check("post rst no done", {31'b0, done_o}, 32'd0);
        run_vec(0);

        // Request with no ack
        @(negedge clk);
        start_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
        @(negedge clk);
        start_i = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("to wait%0d req", k), {31'b0, mem_req_o}, 32'd1);
        end
        @(negedge clk);
        check("to fault", {31'b0, fault_o}, 32'd1);
        check("to req drop", {31'b0, mem_req_o}, 32'd0);
        check("to no done", {31'b0, done_o}, 32'd0);
        @(negedge clk);
        check("to idle", {31'b0, busy_o}, 32'd0);
`else
        repeat (20) @(negedge clk);
        check("no-timeout req held", {31'b0, mem_req_o}, 32'd1);
        check("no-timeout no fault", {31'b0, fault_o}, 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h3333_3333;
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("no-timeout done", {31'b0, done_o}, 32'd1);
        check("no-timeout load", load_data_o, 32'h3333_3333);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
